// File: rtl/rr_pkt_arbiter.sv
// Packet-granular round-robin arbiter: registered one-hot grant held until grant_done.
// Optional forced release after MAX_HOLD cycles when RR_PKT_ARBITER_TIMEOUT_EN is defined.
module rr_pkt_arbiter #(
    parameter int unsigned SEL_WIDTH = 3,
    parameter int unsigned MAX_HOLD  = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2**SEL_WIDTH-1:0]   req,
    input  logic                      grant_done,
    output logic [2**SEL_WIDTH-1:0]   grant,
    output logic [SEL_WIDTH-1:0]      grant_sel,
    output logic                      grant_vld,
    output logic                      hold_timeout
);

    localparam int unsigned N = 2**SEL_WIDTH;

    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("rr_pkt_arbiter: MAX_HOLD must be at least 2");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t               state;
    logic [SEL_WIDTH-1:0] last_sel;
    logic [N-1:0]         masked;
    logic [N-1:0]         pick_vec;
    logic [N-1:0]         win_onehot;
    logic [SEL_WIDTH-1:0] win_sel;
    logic                 win_found;
    logic                 req_any;
    logic                 timeout_hit;
    logic                 rel_now;

    // Requesters above last_sel take priority; otherwise wrap to the lowest requester.
    always_comb begin
        masked     = '0;
        win_sel    = '0;
        win_found  = 1'b0;
        win_onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (SEL_WIDTH'(i) > last_sel) begin
                masked[i] = req[i];
            end
        end
        pick_vec = (|masked) ? masked : req;
        for (int unsigned i = 0; i < N; i++) begin
            if (!win_found && pick_vec[i]) begin
                win_sel   = SEL_WIDTH'(i);
                win_found = 1'b1;
            end
        end
        win_onehot[win_sel] = 1'b1;
    end

    assign req_any = |req;
    assign rel_now = grant_done || timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            grant_sel <= '0;
            grant_vld <= 1'b0;
            last_sel  <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        state     <= BUSY;
                        grant     <= win_onehot;
                        grant_sel <= win_sel;
                        grant_vld <= 1'b1;
                        last_sel  <= win_sel;
                    end
                end
                BUSY: begin
                    if (rel_now) begin
                        if (req_any) begin
                            grant     <= win_onehot;
                            grant_sel <= win_sel;
                            grant_vld <= 1'b1;
                            last_sel  <= win_sel;
                        end else begin
                            state     <= IDLE;
                            grant     <= '0;
                            grant_sel <= '0;
                            grant_vld <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant     <= '0;
                    grant_sel <= '0;
                    grant_vld <= 1'b0;
                end
            endcase
        end
    end

`ifdef RR_PKT_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [CNT_W-1:0] hold_cnt;
    logic             hold_timeout_q;

    assign timeout_hit = (state == BUSY) && !grant_done &&
                         (hold_cnt == CNT_W'(MAX_HOLD - 1));

    // Counter restarts whenever the grant changes hands or the arbiter idles.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt       <= '0;
            hold_timeout_q <= 1'b0;
        end else begin
            hold_timeout_q <= timeout_hit;
            if (state != BUSY || rel_now) begin
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end

    assign hold_timeout = hold_timeout_q;
`else
    assign timeout_hit  = 1'b0;
    assign hold_timeout = 1'b0;
`endif

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
    a_vld_matches:  assert property (@(posedge clk) disable iff (reset) grant_vld == (|grant));
    a_sel_encodes:  assert property (@(posedge clk) disable iff (reset) grant_vld |-> grant[grant_sel]);

endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// Directed self-checking bench for rr_pkt_arbiter with SEL_WIDTH=2, MAX_HOLD=4.
module tb_rr_pkt_arbiter;

    localparam int unsigned SW = 2;
    localparam int unsigned N  = 4;
`ifdef RR_PKT_ARBITER_TIMEOUT_EN
    localparam int HOLD_CHECKS = 3;
`else
    localparam int HOLD_CHECKS = 10;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic          grant_done = 1'b0;
    logic [N-1:0]  grant;
    logic [SW-1:0] grant_sel;
    logic          grant_vld;
    logic          hold_timeout;

    int total = 0;
    int bad   = 0;

    rr_pkt_arbiter #(
        .SEL_WIDTH(SW),
        .MAX_HOLD (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant_done  (grant_done),
        .grant       (grant),
        .grant_sel   (grant_sel),
        .grant_vld   (grant_vld),
        .hold_timeout(hold_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req        = '0;
        grant_done = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=%b", grant, 4'b0000); end
        total++; if (grant_sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=%0d", grant_sel, 0); end
        total++; if (grant_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=%b", grant_vld, 1'b0); end
        total++; if (hold_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=%b", hold_timeout, 1'b0); end
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick();
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b exp=%b", grant, 4'b0100); end
        total++; if (grant_sel !== 2'd2) begin bad++; $display("FAIL single_sel got=%0d exp=%0d", grant_sel, 2); end
        total++; if (grant_vld !== 1'b1) begin bad++; $display("FAIL single_vld got=%b exp=%b", grant_vld, 1'b1); end
        req = '0;
        for (int k = 0; k < HOLD_CHECKS; k++) begin
            tick();
            total++; if (grant !== 4'b0100 || grant_vld !== 1'b1) begin
                bad++; $display("FAIL single_hold cyc=%0d got=%b/%b exp=%b/1", k, grant, grant_vld, 4'b0100);
            end
        end
        grant_done = 1'b1;
        tick();
        grant_done = 1'b0;
        total++; if (grant_vld !== 1'b0 || grant !== 4'b0000) begin
            bad++; $display("FAIL single_release got=%b/%b exp=0000/0", grant, grant_vld);
        end
    endtask

    task automatic test_rotation();
        logic [SW-1:0] exp_seq [5];
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111;
        tick();
        total++; if (grant_sel !== exp_seq[0]) begin bad++; $display("FAIL rot_first got=%0d exp=%0d", grant_sel, exp_seq[0]); end
        for (int k = 1; k < 5; k++) begin
            tick();
            total++; if (grant_sel !== exp_seq[k-1] || grant_vld !== 1'b1) begin
                bad++; $display("FAIL rot_hold k=%0d got=%0d/%b exp=%0d/1", k, grant_sel, grant_vld, exp_seq[k-1]);
            end
            tick();
            grant_done = 1'b1;
            tick();
            grant_done = 1'b0;
            total++; if (grant_sel !== exp_seq[k] || grant_vld !== 1'b1) begin
                bad++; $display("FAIL rot_next k=%0d got=%0d/%b exp=%0d/1", k, grant_sel, grant_vld, exp_seq[k]);
            end
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        req = 4'b0100;
        tick();
        total++; if (grant_sel !== 2'd2) begin bad++; $display("FAIL wrap_setup got=%0d exp=%0d", grant_sel, 2); end
        req        = 4'b0011;
        grant_done = 1'b1;
        tick();
        total++; if (grant_sel !== 2'd0 || grant !== 4'b0001) begin
            bad++; $display("FAIL wrap_to0 got=%0d/%b exp=0/0001", grant_sel, grant);
        end
        tick();
        total++; if (grant_sel !== 2'd1 || grant !== 4'b0010) begin
            bad++; $display("FAIL wrap_to1 got=%0d/%b exp=1/0010", grant_sel, grant);
        end
        tick();
        total++; if (grant_sel !== 2'd0 || grant !== 4'b0001) begin
            bad++; $display("FAIL wrap_skip3 got=%0d/%b exp=0/0001", grant_sel, grant);
        end
        grant_done = 1'b0;
    endtask

    task automatic test_release_idle();
        req        = 4'b0010;
        grant_done = 1'b1;
        tick();
        total++; if (grant_sel !== 2'd1) begin bad++; $display("FAIL idle_setup got=%0d exp=%0d", grant_sel, 1); end
        req = '0;
        tick();
        total++; if (grant !== 4'b0000 || grant_vld !== 1'b0) begin
            bad++; $display("FAIL idle_release got=%b/%b exp=0000/0", grant, grant_vld);
        end
        tick();
        total++; if (grant !== 4'b0000 || grant_vld !== 1'b0) begin
            bad++; $display("FAIL idle_spurious got=%b/%b exp=0000/0", grant, grant_vld);
        end
        grant_done = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0010;
        tick();
        grant_done = 1'b1;
        tick();
        grant_done = 1'b0;
        total++; if (grant !== 4'b0010 || grant_vld !== 1'b1) begin
            bad++; $display("FAIL b2b_regrant got=%b/%b exp=0010/1", grant, grant_vld);
        end
        req = '0;
        grant_done = 1'b1;
        tick();
        grant_done = 1'b0;
    endtask

    task automatic test_reset_mid();
        req = 4'b1000;
        tick();
        total++; if (grant_sel !== 2'd3) begin bad++; $display("FAIL mid_setup got=%0d exp=%0d", grant_sel, 3); end
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
        total++; if (grant !== 4'b0000 || grant_sel !== 2'd0 || grant_vld !== 1'b0 || hold_timeout !== 1'b0) begin
            bad++; $display("FAIL mid_clear got=%b/%0d/%b/%b exp=0000/0/0/0", grant, grant_sel, grant_vld, hold_timeout);
        end
        req = 4'b1000;
        tick();
        total++; if (grant_sel !== 2'd3 || grant !== 4'b1000) begin
            bad++; $display("FAIL mid_regrant got=%0d/%b exp=3/1000", grant_sel, grant);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0011;
        tick();
        total++; if (grant_sel !== 2'd0) begin bad++; $display("FAIL to_setup got=%0d exp=%0d", grant_sel, 0); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++; if (grant_sel !== 2'd0 || hold_timeout !== 1'b0) begin
                bad++; $display("FAIL to_early k=%0d got=%0d/%b exp=0/0", k, grant_sel, hold_timeout);
            end
        end
        tick();
`ifdef RR_PKT_ARBITER_TIMEOUT_EN
        total++; if (hold_timeout !== 1'b1 || grant_sel !== 2'd1) begin
            bad++; $display("FAIL to_fire got=%b/%0d exp=1/1", hold_timeout, grant_sel);
        end
        tick();
        total++; if (hold_timeout !== 1'b0 || grant_sel !== 2'd1) begin
            bad++; $display("FAIL to_pulse got=%b/%0d exp=0/1", hold_timeout, grant_sel);
        end
`else
        for (int k = 0; k < 8; k++) begin
            total++; if (hold_timeout !== 1'b0 || grant_sel !== 2'd0 || grant_vld !== 1'b1) begin
                bad++; $display("FAIL to_unbounded k=%0d got=%b/%0d/%b exp=0/0/1", k, hold_timeout, grant_sel, grant_vld);
            end
            tick();
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap_skip();
        test_release_idle();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
